id_stage_lmsm: RTL and testbench

// - Parametrised decode stage with a registered ID/RR pipeline latch and valid/ready handshakes on both sides.
// - Sits between the IF/ID latch and register read.
// - Extracts register fields, immediate and control class, and selects the immediate per opcode.
// - Expands LM/SM (opcodes 0110/0111) into one micro-op per set bit of instr[7:0]; upstream stalls while it does so.

---
 rtl/id_stage_lmsm.sv | 201 ++++++++++++++++++++
 tb/tb_id_stage_lmsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_lmsm.sv
// Decode stage with a registered ID/RR latch and valid/ready handshakes on both sides.
// LM/SM instructions are expanded into one micro-op per set bit of the register list.
module id_stage_lmsm #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NREGS     = 8,
    parameter int unsigned LHI_SHIFT = 7,
    localparam int unsigned REG_W    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [REG_W-1:0]  out_ra,
    output logic [REG_W-1:0]  out_rb,
    output logic [REG_W-1:0]  out_rc,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        out_imm_sel,
    output logic              out_lmsm,
    output logic              out_first,
    output logic              out_last
);

    localparam int unsigned KW = REG_W + 1;

    typedef enum logic [0:0] {StIdle, StSeq} state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   pc_q, pc_d, instr_q, instr_d, imm_q, imm_d;
    logic [REG_W-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [1:0]          imm_sel_q, imm_sel_d;
    logic                lmsm_q, lmsm_d, first_q, first_d, last_q, last_d;
    logic [NREGS-1:0]    list_q, list_d;
    logic [KW-1:0]       k_q, k_d;

    logic                accept, xfer, is_lmsm;
    logic [3:0]          opcode;
    logic [NREGS-1:0]    in_list, in_rem, seq_rem;
    logic [DATA_W-1:0]   dec_imm;
    logic [1:0]          dec_sel;

    function automatic logic [REG_W-1:0] lowest_bit(input logic [NREGS-1:0] v);
        lowest_bit = '0;
        for (int i = int'(NREGS) - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = REG_W'(i);
        end
    endfunction

    // Immediate selection per opcode
    always_comb begin
        opcode  = in_instr[15:12];
        is_lmsm = (opcode == 4'b0110) || (opcode == 4'b0111);
        dec_imm = '0;
        dec_sel = 2'd3;
        case (opcode)
            4'b0001, 4'b0100, 4'b0101, 4'b1100: begin
                dec_imm = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
                dec_sel = 2'd0;
            end
            4'b0011: begin
                dec_imm = DATA_W'(in_instr[8:0]) << LHI_SHIFT;
                dec_sel = 2'd1;
            end
            4'b1000: begin
                dec_imm = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
                dec_sel = 2'd2;
            end
            default: begin
                dec_imm = '0;
                dec_sel = 2'd3;
            end
        endcase
    end

    always_comb begin
        in_list = in_instr[NREGS-1:0];
        in_rem  = in_list & (in_list - NREGS'(1));
        seq_rem = list_q & (list_q - NREGS'(1));
        accept  = in_valid && in_ready;
        xfer    = valid_q && out_ready;

        state_d   = state_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        lmsm_d    = lmsm_q;
        first_d   = first_q;
        last_d    = last_q;
        list_d    = list_q;
        k_d       = k_q;

        if (flush) begin
            valid_d = 1'b0;
            state_d = StIdle;
            list_d  = '0;
            k_d     = '0;
        end else if (accept) begin
            valid_d   = 1'b1;
            pc_d      = in_pc;
            instr_d   = in_instr;
            ra_d      = REG_W'(in_instr[11:9]);
            rb_d      = REG_W'(in_instr[8:6]);
            rc_d      = REG_W'(in_instr[5:3]);
            imm_d     = dec_imm;
            imm_sel_d = dec_sel;
            lmsm_d    = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b1;
            list_d    = '0;
            k_d       = '0;
            if (is_lmsm) begin
                // An empty list is swallowed without producing an op.
                if (in_list == '0) begin
                    valid_d = 1'b0;
                end else begin
                    rb_d    = lowest_bit(in_list);
                    imm_d   = '0;
                    lmsm_d  = 1'b1;
                    first_d = 1'b1;
                    last_d  = (in_rem == '0);
                    list_d  = in_rem;
                    state_d = (in_rem == '0) ? StIdle : StSeq;
                end
            end
        end else if (xfer) begin
            if (state_q == StSeq && !last_q) begin
                k_d     = k_q + KW'(1);
                rb_d    = lowest_bit(list_q);
                imm_d   = DATA_W'(k_d);
                first_d = 1'b0;
                last_d  = (seq_rem == '0);
                list_d  = seq_rem;
            end else begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            imm_q     <= '0;
            imm_sel_q <= '0;
            lmsm_q    <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            list_q    <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            lmsm_q    <= lmsm_d;
            first_q   <= first_d;
            last_q    <= last_d;
            list_q    <= list_d;
            k_q       <= k_d;
        end
    end

    always_comb begin
        in_ready    = !rst && !flush && (state_q == StIdle) && (!valid_q || out_ready);
        out_valid   = valid_q;
        out_pc      = pc_q;
        out_instr   = instr_q;
        out_ra      = ra_q;
        out_rb      = rb_q;
        out_rc      = rc_q;
        out_imm     = imm_q;
        out_imm_sel = imm_sel_q;
        out_lmsm    = lmsm_q;
        out_first   = first_q;
        out_last    = last_q;
    end

endmodule

// File: tb/tb_id_stage_lmsm.sv
// Bench for id_stage_lmsm: an op-queue model of the decode stage checked every cycle,
// plus hand-computed spot checks on the directed vectors.
module tb_id_stage_lmsm;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_pc, in_instr, out_pc, out_instr, out_imm;
    logic [2:0]  out_ra, out_rb, out_rc;
    logic [1:0]  out_imm_sel;
    logic        out_lmsm, out_first, out_last;

    id_stage_lmsm #(.DATA_W(16), .NREGS(8), .LHI_SHIFT(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc), .out_imm(out_imm),
        .out_imm_sel(out_imm_sel), .out_lmsm(out_lmsm), .out_first(out_first),
        .out_last(out_last)
    );

    typedef struct {
        logic [15:0] pc, instr, imm;
        logic [2:0]  ra, rb, rc;
        logic [1:0]  sel;
        logic        lmsm, first, last;
    } op_t;

    op_t exp_q[$];
    bit  zero_exp = 1'b0;
    bit  chk_en   = 1'b0;
    int  n_total  = 0;
    int  n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Stage is busy while a multi-op LM/SM sequence occupies the latch.
    function automatic bit model_idle();
        if (exp_q.size() == 0) return 1'b1;
        return !(exp_q[0].lmsm && !(exp_q[0].first && exp_q[0].last));
    endfunction

    task automatic model_accept(input logic [15:0] pc, input logic [15:0] instr);
        op_t o;
        int  op, v, cnt, k;
        op      = int'(instr[15:12]);
        o.pc    = pc;
        o.instr = instr;
        o.ra    = instr[11:9];
        o.rb    = instr[8:6];
        o.rc    = instr[5:3];
        o.lmsm  = 1'b0;
        o.first = 1'b0;
        o.last  = 1'b1;
        o.sel   = 2'd3;
        o.imm   = 16'h0;
        if (op == 6 || op == 7) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) if (instr[i]) cnt++;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (instr[i]) begin
                    o.rb    = 3'(i);
                    o.imm   = 16'(k);
                    o.lmsm  = 1'b1;
                    o.first = (k == 0);
                    o.last  = (k == cnt - 1);
                    exp_q.push_back(o);
                    k++;
                end
            end
        end else begin
            case (op)
                1, 4, 5, 12: begin
                    v = int'(instr[5:0]);
                    if (v >= 32) v -= 64;
                    o.imm = 16'(v);
                    o.sel = 2'd0;
                end
                3: begin
                    v     = int'(instr[8:0]) * 128;
                    o.imm = 16'(v);
                    o.sel = 2'd1;
                end
                8: begin
                    v = int'(instr[8:0]);
                    if (v >= 256) v -= 512;
                    o.imm = 16'(v);
                    o.sel = 2'd2;
                end
                default: begin
                    o.imm = 16'h0;
                    o.sel = 2'd3;
                end
            endcase
            exp_q.push_back(o);
        end
    endtask

    // Model update at the active edge, using only inputs and model state.
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            exp_q.delete();
            zero_exp = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            acc = in_valid && model_idle() && (exp_q.size() == 0 || out_ready);
            if (exp_q.size() > 0 && out_ready) exp_q.delete(0);
            if (acc) begin
                zero_exp = 1'b0;
                model_accept(in_pc, in_instr);
            end
        end
    end

    always @(negedge clk) begin
        bit  exp_rdy;
        op_t h;
        if (chk_en) begin
            exp_rdy = !rst && !flush && model_idle() && (exp_q.size() == 0 || out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                chk("out_pc", 32'(out_pc), 32'(h.pc));
                chk("out_instr", 32'(out_instr), 32'(h.instr));
                chk("out_ra", 32'(out_ra), 32'(h.ra));
                chk("out_rb", 32'(out_rb), 32'(h.rb));
                chk("out_rc", 32'(out_rc), 32'(h.rc));
                chk("out_imm", 32'(out_imm), 32'(h.imm));
                chk("out_imm_sel", 32'(out_imm_sel), 32'(h.sel));
                chk("out_lmsm", 32'(out_lmsm), 32'(h.lmsm));
                chk("out_first", 32'(out_first), 32'(h.first));
                chk("out_last", 32'(out_last), 32'(h.last));
            end else if (zero_exp) begin
                chk("rst_zero_data", {out_pc, out_imm}, 32'h0);
                chk("rst_zero_instr", 32'(out_instr), 32'h0);
                chk("rst_zero_regs", 32'({out_ra, out_rb, out_rc, out_imm_sel}), 32'h0);
                chk("rst_zero_flags", 32'({out_lmsm, out_first, out_last}), 32'h0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                       input logic rdy, input logic fl, input logic r);
        rst       = r;
        flush     = fl;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 16'h0000, 16'h1A7E, 1, 0, 1);
        chk_en = 1'b1;
        cyc(1, 16'h0000, 16'h1A7E, 1, 0, 1);
        chk("lit_reset_valid", 32'(out_valid), 32'h0);
        chk("lit_reset_ready", 32'(in_ready), 32'h0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_idle_ready", 32'(in_ready), 32'h1);

        // ADI
        cyc(1, 16'h0010, 16'h1A7E, 1, 0, 0);
        chk("lit_adi_valid", 32'(out_valid), 32'h1);
        chk("lit_adi_ra_rb", 32'({out_ra, out_rb}), 32'({3'd5, 3'd1}));
        chk("lit_adi_imm", 32'(out_imm), 32'hFFFE);
        chk("lit_adi_sel_last", 32'({out_imm_sel, out_last}), 32'({2'd0, 1'b1}));

        // LHI then downstream stall
        cyc(1, 16'h0012, 16'h3F81, 1, 0, 0);
        chk("lit_lhi_imm", 32'(out_imm), 32'hC080);
        chk("lit_lhi_sel", 32'(out_imm_sel), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1, 16'h0099, 16'h1111, 0, 0, 0);
        chk("lit_hold_imm", 32'(out_imm), 32'hC080);
        chk("lit_hold_pc", 32'(out_pc), 32'h0012);
        chk("lit_hold_ready", 32'(in_ready), 32'h0);

        // SM with list 0b00100101
        cyc(1, 16'h0020, 16'h7A25, 1, 0, 0);
        chk("lit_sm1", 32'({out_rb, out_imm[3:0], out_first, out_last}), 32'({3'd0, 4'd0, 2'b10}));
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_sm2", 32'({out_rb, out_imm[3:0], out_first, out_last}), 32'({3'd2, 4'd1, 2'b00}));
        chk("lit_sm2_ready", 32'(in_ready), 32'h0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_sm3", 32'({out_rb, out_imm[3:0], out_first, out_last}), 32'({3'd5, 4'd2, 2'b01}));
        chk("lit_sm3_ready", 32'(in_ready), 32'h0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_sm_done", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));

        // LM empty list, then LM single-bit list
        cyc(1, 16'h0030, 16'h6000, 1, 0, 0);
        chk("lit_lm0", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        cyc(1, 16'h0032, 16'h6E80, 1, 0, 0);
        chk("lit_lm80", 32'({out_rb, out_lmsm, out_first, out_last}), 32'({3'd7, 3'b111}));

        // LM 0xFF flushed during its second micro-op
        cyc(1, 16'h0034, 16'h60FF, 1, 0, 0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_ff2_rb", 32'(out_rb), 32'h1);
        cyc(1, 16'h0036, 16'h1A7E, 1, 1, 0);
        chk("lit_flush", 32'({out_valid, in_ready}), 32'h0);
        cyc(1, 16'h0040, 16'h1A7E, 1, 0, 0);
        chk("lit_after_flush", 32'({out_pc, out_imm}), {16'h0040, 16'hFFFE});

        // Back-to-back decodes
        cyc(1, 16'h0042, 16'h4283, 1, 0, 0);
        cyc(1, 16'h0044, 16'h56BF, 1, 0, 0);
        chk("lit_sw_imm", 32'(out_imm), 32'hFFFF);
        cyc(1, 16'h0046, 16'hC0E0, 1, 0, 0);
        chk("lit_beq_imm", 32'(out_imm), 32'hFFE0);
        cyc(1, 16'h0048, 16'h8F00, 1, 0, 0);
        chk("lit_jal", 32'({out_imm, 14'h0, out_imm_sel}), {16'hFF00, 16'h0002});

        // Reset mid-sequence
        cyc(1, 16'h0050, 16'h60FF, 1, 0, 0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 1);
        chk("lit_midrst_valid", 32'(out_valid), 32'h0);
        chk("lit_midrst_data", {out_pc, out_imm}, 32'h0);
        chk("lit_midrst_flags", 32'({out_rb, out_lmsm, out_last}), 32'h0);
        cyc(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("lit_post_rst_ready", 32'(in_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
